// File: rtl/part_2_trgt_upload_buf_pkg.sv
// Shared types and defaults for the upload-side capture buffer.
package part_2_pkg;

  localparam int DW_DEF    = 9;
  localparam int DEPTH_DEF = 8;
  localparam int SEQ_W_DEF = 16;

  typedef struct packed {
    logic [SEQ_W_DEF-1:0] seq;
    logic [DW_DEF-1:0]    data;
  } up_vec_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/part_2_trgt_upload_buf_cs_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with an explicit fill counter.
module cs_sync_fifo
  import part_2_pkg::*;
#(
  parameter type T     = up_vec_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  // A pop frees the slot the simultaneous push needs, so full+push+pop is lossless.
  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & ((cnt != FULL_CNT) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign fill  = cnt;

endmodule

// File: rtl/part_2_trgt_upload_buf.sv
// Captures {valid,o_data} on each mission-clock rising edge, tags it with a
// sequence number and buffers it for the export FSM; counts dropped samples.
module part_2_trgt_upload_buf
  import part_2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_0_h,
  input  logic                     freeze_i,
  input  logic                     valid,
  input  logic [7:0]               o_data,
  output logic                     vec_valid_o,
  output logic [DW-1:0]            vec_data_o,
  output logic [SEQ_W-1:0]         vec_seq_o,
  input  logic                     vec_ready_i,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [DW-1:0]    data;
  } vec_t;

  logic             clk_0_h_d;
  logic             strobe;
  logic             push;
  logic             pop;
  logic             drop;
  logic             empty;
  logic             full;
  logic [SEQ_W-1:0] seq;
  vec_t             wvec;
  vec_t             head;

  assign strobe = clk_0_h & ~clk_0_h_d;
  assign push   = strobe & ~freeze_i;
  assign pop    = ~empty & vec_ready_i;
  assign drop   = push & full & ~pop;

  assign wvec.seq  = seq;
  assign wvec.data = {valid, o_data};

  cs_sync_fifo #(
    .T     (vec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (wvec),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .fill  (fill_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_0_h_d  <= 1'b0;
      seq        <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      clk_0_h_d <= clk_0_h;
      if (push && !drop) seq <= seq + SEQ_W'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= sat_inc8(drop_cnt_o);
      end
    end
  end

  // Head fields are masked when empty so RAM garbage never leaks out after reset.
  assign vec_valid_o = ~empty;
  assign vec_data_o  = empty ? '0 : head.data;
  assign vec_seq_o   = empty ? '0 : head.seq;
  assign full_o      = full;

endmodule

// File: tb/tb_part_2_trgt_upload_buf.sv
// Randomized bench comparing two buffer instances (DEPTH 8 and 4) against a queue model.
module tb_part_2_trgt_upload_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h = 1'b0, frz = 1'b0, v = 1'b0, rdy = 1'b0;
  logic [7:0]  d = 8'h00;

  logic        a_valid, a_full, a_ovf;
  logic [8:0]  a_data;
  logic [15:0] a_seq;
  logic [3:0]  a_fill;
  logic [7:0]  a_drop;

  logic        b_valid, b_full, b_ovf;
  logic [8:0]  b_data;
  logic [15:0] b_seq;
  logic [2:0]  b_fill;
  logic [7:0]  b_drop;

  part_2_trgt_upload_buf #(.DW(9), .DEPTH(8), .SEQ_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .clk_0_h(h), .freeze_i(frz), .valid(v), .o_data(d),
    .vec_valid_o(a_valid), .vec_data_o(a_data), .vec_seq_o(a_seq), .vec_ready_i(rdy),
    .fill_o(a_fill), .full_o(a_full), .overflow_o(a_ovf), .drop_cnt_o(a_drop)
  );

  part_2_trgt_upload_buf #(.DW(9), .DEPTH(4), .SEQ_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .clk_0_h(h), .freeze_i(frz), .valid(v), .o_data(d),
    .vec_valid_o(b_valid), .vec_data_o(b_data), .vec_seq_o(b_seq), .vec_ready_i(rdy),
    .fill_o(b_fill), .full_o(b_full), .overflow_o(b_ovf), .drop_cnt_o(b_drop)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit [24:0] mq [2][$];
  int        mseq [2];
  int        mdrop [2];
  bit        movf [2];
  int        mdepth [2] = '{8, 4};
  int        captured [2];
  int        dropped [2];
  int        popped [2];
  bit        mprev;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mseq[k] = 0; mdrop[k] = 0; movf[k] = 1'b0;
      captured[k] = 0; dropped[k] = 0; popped[k] = 0;
    end
    mprev = 1'b0;
  endtask

  task automatic model_step();
    bit push;
    push = h & ~mprev & ~frz;
    for (int k = 0; k < 2; k++) begin
      if (mq[k].size() != 0 && rdy) begin
        void'(mq[k].pop_front());
        popped[k]++;
      end
      if (push) begin
        captured[k]++;
        if (mq[k].size() < mdepth[k]) begin
          mq[k].push_back({16'(mseq[k]), v, d});
          mseq[k] = (mseq[k] + 1) % 65536;
        end else begin
          dropped[k]++;
          movf[k] = 1'b1;
          if (mdrop[k] < 255) mdrop[k]++;
        end
      end
    end
    mprev = h;
  endtask

  task automatic cmp_one(input int k, input string p, input logic ov, input logic [8:0] od,
                         input logic [15:0] os, input int ofill, input logic ofull,
                         input logic oovf, input logic [7:0] odrop);
    bit [24:0] hd;
    bit        ev;
    ev = (mq[k].size() != 0);
    hd = ev ? mq[k][0] : 25'd0;
    chk({p, "_valid"}, ov, ev);
    chk({p, "_data"}, od, hd[8:0]);
    chk({p, "_seq"}, os, hd[24:9]);
    chk({p, "_fill"}, ofill, mq[k].size());
    chk({p, "_full"}, ofull, mq[k].size() == mdepth[k]);
    chk({p, "_ovf"}, oovf, movf[k]);
    chk({p, "_drop"}, odrop, mdrop[k]);
  endtask

  task automatic compare_all();
    cmp_one(0, "a", a_valid, a_data, a_seq, a_fill, a_full, a_ovf, a_drop);
    cmp_one(1, "b", b_valid, b_data, b_seq, b_fill, b_full, b_ovf, b_drop);
  endtask

  task automatic cycle(input logic hh, input logic ff, input logic vv,
                       input logic [7:0] dd, input logic rr);
    h = hh; frz = ff; v = vv; d = dd; rdy = rr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_a_data"}, a_data, 0);
    chk({tag, "_a_seq"}, a_seq, 0);
    chk({tag, "_a_fill"}, a_fill, 0);
    chk({tag, "_a_full"}, a_full, 0);
    chk({tag, "_a_ovf"}, a_ovf, 0);
    chk({tag, "_a_drop"}, a_drop, 0);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_b_fill"}, b_fill, 0);
    chk({tag, "_b_drop"}, b_drop, 0);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    chk_zero_outputs("por");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();

    // Single edge: payload 1A5 appears one cycle after the capturing edge.
    cycle(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    chk("single_valid", a_valid, 1);
    chk("single_data", a_data, 9'h1A5);
    chk("single_seq", a_seq, 0);
    chk("single_fill", a_fill, 1);
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);

    // Burst to full, then one more edge is dropped.
    for (int i = 1; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'(i), 8'(8'h10 + i), 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("burst_full", a_full, 1);
    chk("burst_fill", a_fill, 8);
    chk("burst_ovf0", a_ovf, 0);
    cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_flag", a_ovf, 1);
    chk("ovf_drop", a_drop, 1);
    chk("ovf_fill", a_fill, 8);

    // Full with simultaneous push and pop: no drop, tail tagged 8.
    cycle(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1);
    chk("pp_fill", a_fill, 8);
    chk("pp_drop", a_drop, 1);
    chk("pp_head", a_seq, 1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", a_seq, i + 1);
      if (i == 7) chk("tail_data", a_data, 9'h03C);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("drained_valid", a_valid, 0);

    // Frozen mission clock: edges neither capture nor count as drops.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    end
    chk("frz_fill", a_fill, 2);
    chk("frz_drop", a_drop, 1);
    cycle(1'b1, 1'b0, 1'b0, 8'h99, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("frz_seq_cont", a_seq, 11);

    // Asynchronous reset mid-traffic.
    rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    model_reset();
    #2;
    rst = 1'b0;
    h = 1'b0; rdy = 1'b0; frz = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("rst_seq0", a_seq, 0);
    chk("rst_data", a_data, 9'h15A);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random stalls and freezes, then sustained overflow to saturate drop_cnt.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom),
            1'($urandom_range(0, 15) == 0));
      cycle(1'b0, 1'($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom),
            1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0, 1'($urandom), 8'($urandom), 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("sat_a_drop", a_drop, 255);
    chk("sat_b_drop", b_drop, 255);
    chk("sat_b_ovf", b_ovf, 1);
    chk("inv_a", captured[0] - dropped[0] - popped[0], a_fill);
    chk("inv_b", captured[1] - dropped[1] - popped[1], b_fill);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
